// File: rtl/game_ctrl_if.sv
// Game sequencer bus: button/event inputs toward the controller, status outputs back.
interface game_ctrl_if #(
  parameter int unsigned LEVEL_W = 10
);
  logic               tick;
  logic               start_btn;
  logic               pause_btn;
  logic               collision;
  logic               goal;
  logic [LEVEL_W-1:0] level;
  logic [1:0]         lives;
  logic [2:0]         state;
  logic               freeze;
  logic               rst_player;
  logic               game_over;
  logic               win;

  // Driver side: buttons, frame tick and update-block events.
  modport master (
    output tick, start_btn, pause_btn, collision, goal,
    input  level, lives, state, freeze, rst_player, game_over, win
  );

  // Controller side.
  modport slave (
    input  tick, start_btn, pause_btn, collision, goal,
    output level, lives, state, freeze, rst_player, game_over, win
  );
endinterface

// File: rtl/game_ctrl.sv
// Game sequencer: run/pause/death/level-up/game-over FSM with level and lives tracking.
module game_ctrl #(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned MAX_LEVEL     = 9,
  parameter int unsigned LEVEL_W       = 10,
  parameter int unsigned DEATH_TICKS   = 30,
  parameter int unsigned LEVELUP_TICKS = 60
) (
  input  logic        clk,
  input  logic        reset,
  game_ctrl_if.slave  bus
);

  localparam int unsigned TIMER_MAX = (DEATH_TICKS > LEVELUP_TICKS) ? DEATH_TICKS : LEVELUP_TICKS;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    PAUSED   = 3'd2,
    DYING    = 3'd3,
    LEVEL_UP = 3'd4,
    OVER     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [1:0]         lives_q, lives_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               win_q, win_d;
  logic               rst_player_q, rst_player_d;
  logic               freeze_q;
  logic               game_over_q;
  logic               start_prev, pause_prev;
  logic               start_rise, pause_rise;

  assign start_rise = bus.start_btn & ~start_prev;
  assign pause_rise = bus.pause_btn & ~pause_prev;

  // State and output registers; button history resets high so a held button is not an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      level_q      <= LEVEL_W'(1);
      lives_q      <= 2'(LIVES_INIT);
      timer_q      <= '0;
      win_q        <= 1'b0;
      rst_player_q <= 1'b0;
      freeze_q     <= 1'b1;
      game_over_q  <= 1'b0;
      start_prev   <= 1'b1;
      pause_prev   <= 1'b1;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      timer_q      <= timer_d;
      win_q        <= win_d;
      rst_player_q <= rst_player_d;
      freeze_q     <= (state_d != PLAY);
      game_over_q  <= (state_d == OVER);
      start_prev   <= bus.start_btn;
      pause_prev   <= bus.pause_btn;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    lives_d      = lives_q;
    timer_d      = timer_q;
    win_d        = win_q;
    rst_player_d = 1'b0;

    case (state_q)
      IDLE: begin
        level_d = LEVEL_W'(1);
        lives_d = 2'(LIVES_INIT);
        win_d   = 1'b0;
        if (start_rise) begin
          state_d      = PLAY;
          rst_player_d = 1'b1;
        end
      end
      PLAY: begin
        if (bus.collision) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            win_d   = 1'b0;
            state_d = OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            timer_d = TIMER_W'(DEATH_TICKS);
            state_d = DYING;
          end
        end else if (bus.goal) begin
          if (level_q >= LEVEL_W'(MAX_LEVEL)) begin
            win_d   = 1'b1;
            state_d = OVER;
          end else begin
            timer_d = TIMER_W'(LEVELUP_TICKS);
            state_d = LEVEL_UP;
          end
        end else if (pause_rise) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_rise) state_d = PLAY;
      end
      DYING, LEVEL_UP: begin
        if (bus.tick) begin
          if (timer_q <= TIMER_W'(1)) begin
            timer_d      = '0;
            rst_player_d = 1'b1;
            state_d      = PLAY;
            if (state_q == LEVEL_UP && level_q < LEVEL_W'(MAX_LEVEL))
              level_d = level_q + LEVEL_W'(1);
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
      end
      OVER: begin
        if (start_rise) begin
          level_d = LEVEL_W'(1);
          lives_d = 2'(LIVES_INIT);
          win_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.level      = level_q;
  assign bus.lives      = lives_q;
  assign bus.freeze     = freeze_q;
  assign bus.rst_player = rst_player_q;
  assign bus.game_over  = game_over_q;
  assign bus.win        = win_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed game scenarios plus random play against a rule model.
module tb_game_ctrl;

  localparam int unsigned LI   = 3;
  localparam int unsigned MAXL = 9;
  localparam int unsigned LW   = 10;
  localparam int unsigned DT   = 30;
  localparam int unsigned LT   = 60;

  localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSED = 2, S_DYING = 3, S_LVLUP = 4, S_OVER = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  game_ctrl_if #(.LEVEL_W(LW)) bus ();

  game_ctrl #(
    .LIVES_INIT(LI), .MAX_LEVEL(MAXL), .LEVEL_W(LW),
    .DEATH_TICKS(DT), .LEVELUP_TICKS(LT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Game model expressed directly in terms of the game rules.
  int m_state, m_level, m_lives, m_timer;
  bit m_win, m_rp, m_prev_start, m_prev_pause;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rs, st, pa, ti, co, go);
    bit s_r, p_r;
    if (rs) begin
      m_state = S_IDLE; m_level = 1; m_lives = LI; m_timer = 0;
      m_win = 0; m_rp = 0; m_prev_start = 1; m_prev_pause = 1;
      return;
    end
    s_r = st && !m_prev_start;
    p_r = pa && !m_prev_pause;
    m_prev_start = st;
    m_prev_pause = pa;
    m_rp = 0;
    if (m_state == S_IDLE) begin
      m_level = 1; m_lives = LI; m_win = 0;
      if (s_r) begin m_state = S_PLAY; m_rp = 1; end
    end else if (m_state == S_PLAY) begin
      if (co) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        if (m_lives == 0) begin m_state = S_OVER; m_win = 0; end
        else begin m_state = S_DYING; m_timer = DT; end
      end else if (go) begin
        if (m_level == MAXL) begin m_state = S_OVER; m_win = 1; end
        else begin m_state = S_LVLUP; m_timer = LT; end
      end else if (p_r) m_state = S_PAUSED;
    end else if (m_state == S_PAUSED) begin
      if (p_r) m_state = S_PLAY;
    end else if (m_state == S_DYING || m_state == S_LVLUP) begin
      if (ti) begin
        m_timer = m_timer - 1;
        if (m_timer == 0) begin
          if (m_state == S_LVLUP && m_level < MAXL) m_level = m_level + 1;
          m_state = S_PLAY;
          m_rp = 1;
        end
      end
    end else if (m_state == S_OVER) begin
      if (s_r) begin m_state = S_IDLE; m_level = 1; m_lives = LI; m_win = 0; end
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".state"},      32'(bus.state),      32'(m_state));
    chk({ctx, ".level"},      32'(bus.level),      32'(m_level));
    chk({ctx, ".lives"},      32'(bus.lives),      32'(m_lives));
    chk({ctx, ".freeze"},     32'(bus.freeze),     32'(m_state != S_PLAY));
    chk({ctx, ".rst_player"}, 32'(bus.rst_player), 32'(m_rp));
    chk({ctx, ".game_over"},  32'(bus.game_over),  32'(m_state == S_OVER));
    chk({ctx, ".win"},        32'(bus.win),        32'(m_win));
  endtask

  // Drive one clock of inputs, advance the model, compare after the edge.
  task automatic step(input string ctx, input bit rs, st, pa, ti, co, go);
    @(negedge clk);
    reset         = rs;
    bus.start_btn = st;
    bus.pause_btn = pa;
    bus.tick      = ti;
    bus.collision = co;
    bus.goal      = go;
    model_update(rs, st, pa, ti, co, go);
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) step(ctx, 0, 0, 0, 0, 0, 0);
  endtask

  // Feed ticks with random gaps and ignored-event noise until the model returns to PLAY.
  task automatic run_timer(input string ctx);
    int guard = 0;
    while (m_state != S_PLAY && guard < 2000) begin
      guard++;
      step(ctx, 0, 0, 1'($urandom_range(0, 3) == 0), 1,
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
      for (int g = $urandom_range(0, 3); g > 0 && m_state != S_PLAY; g--)
        step(ctx, 0, 0, 1'($urandom_range(0, 3) == 0), 0,
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
    end
    if (guard >= 2000) begin
      vectors++;
      miscompares++;
      $error("FAIL %s.timeout: observed state %0d expected %0d", ctx, m_state, S_PLAY);
    end
    step({ctx, ".settle"}, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic level_up(input string ctx);
    step(ctx, 0, 0, 0, 1'($urandom_range(0, 1)), 0, 1);
    run_timer(ctx);
  endtask

  initial begin
    bus.tick = 0; bus.start_btn = 0; bus.pause_btn = 0; bus.collision = 0; bus.goal = 0;
    model_update(1, 0, 0, 0, 0, 0);

    // Reset state
    for (int i = 0; i < 3; i++) step("reset", 1, 0, 0, 0, 0, 0);
    chk("reset_freeze", 32'(bus.freeze), 32'd1);
    idle("idle", 2);

    // Start: one rst_player pulse, holding start has no further effect
    step("start", 0, 1, 0, 0, 0, 0);
    chk("start_rp", 32'(bus.rst_player), 32'd1);
    for (int i = 0; i < 4; i++) step("start_hold", 0, 1, 0, 0, 0, 0);
    chk("start_hold_rp", 32'(bus.rst_player), 32'd0);
    idle("play", 2);

    // Goal -> LEVEL_UP -> level 2
    level_up("lvlup1");
    chk("lvlup1_level", 32'(bus.level), 32'd2);

    // Collision with lives 3 -> DYING
    step("coll1", 0, 0, 0, 0, 1, 0);
    chk("coll1_state", 32'(bus.state), 32'(S_DYING));
    run_timer("dying1");

    // Pause, ignored events while paused, unpause
    step("pause_on", 0, 0, 1, 0, 0, 0);
    chk("pause_state", 32'(bus.state), 32'(S_PAUSED));
    step("paused_ev", 0, 0, 1, 1, 1, 1);
    step("paused_ev", 0, 0, 0, 0, 1, 0);
    step("paused_ev", 0, 0, 0, 1, 0, 1);
    step("pause_off", 0, 0, 1, 0, 0, 0);
    chk("unpause_state", 32'(bus.state), 32'(S_PLAY));
    step("pause_hold", 0, 0, 1, 0, 0, 0);
    idle("play", 1);

    // Collision and goal together with lives 2
    step("coll_goal", 0, 0, 0, 0, 1, 1);
    chk("coll_goal_lives", 32'(bus.lives), 32'd1);
    run_timer("dying2");

    // Climb to MAX_LEVEL, then clearing it wins
    for (int l = 2; l < MAXL; l++) level_up("climb");
    chk("climb_level", 32'(bus.level), 32'(MAXL));
    step("win_goal", 0, 0, 0, 1, 0, 1);
    chk("win_flag", 32'(bus.win), 32'd1);
    idle("over", 3);

    // OVER -> IDLE -> new game, lose all lives
    step("to_idle", 0, 1, 0, 0, 0, 0);
    chk("to_idle_lives", 32'(bus.lives), 32'(LI));
    step("rel", 0, 0, 0, 0, 0, 0);
    step("start2", 0, 1, 0, 0, 0, 0);
    step("rel", 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step("coll", 0, 0, 0, 0, 1, 0);
      run_timer("dying3");
    end
    step("last_coll", 0, 0, 0, 0, 1, 0);
    chk("lose_over", 32'(bus.game_over), 32'd1);
    chk("lose_win", 32'(bus.win), 32'd0);
    idle("over2", 2);

    // New game, reset mid LEVEL_UP at level 4 with start held across release
    step("to_idle2", 0, 1, 0, 0, 0, 0);
    step("rel", 0, 0, 0, 0, 0, 0);
    step("start3", 0, 1, 0, 0, 0, 0);
    step("rel", 0, 0, 0, 0, 0, 0);
    for (int l = 1; l < 4; l++) level_up("climb2");
    step("goal4", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step("lvl4_ticks", 0, 0, 0, 1, 0, 0);
    step("mid_reset", 1, 1, 0, 0, 0, 0);
    chk("mid_reset_level", 32'(bus.level), 32'd1);
    chk("mid_reset_rp", 32'(bus.rst_player), 32'd0);
    for (int i = 0; i < 4; i++) step("held_start", 0, 1, 0, 1, 0, 0);
    chk("held_start_state", 32'(bus.state), 32'(S_IDLE));
    step("rel", 0, 0, 0, 0, 0, 0);
    step("start4", 0, 1, 0, 0, 0, 0);

    // Random play against the model
    for (int i = 0; i < 3000; i++)
      step("rand", 0, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1) == 0), 1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 30) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer between the input buttons and the player, environment and update blocks.
- Owns the run/pause/death/level-up/game-over state machine, the level number and the lives count.
- Drives the freeze strobe that gates player and bar motion, and the one-cycle player-reset pulse.
- Consumes collision and goal events from the update block; frame timing comes from a one-cycle tick strobe.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..3).
- MAX_LEVEL, 9, last level; clearing it wins the game.
- LEVEL_W, 10, width of the level output.
- DEATH_TICKS, 30, tick count spent in DYING (>=1).
- LEVELUP_TICKS, 60, tick count spent in LEVEL_UP (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide frame strobe (environment rate).
- start_btn  in  1  start button, already synchronised, level-sensitive.
- pause_btn  in  1  pause button, already synchronised, level-sensitive.
- collision  in  1  player overlaps a bar; sampled every clk.
- goal  in  1  player reached the finish row; sampled every clk.
- level  out  LEVEL_W  current level, 1..MAX_LEVEL.
- lives  out  2  remaining lives.
- state  out  3  IDLE=0, PLAY=1, PAUSED=2, DYING=3, LEVEL_UP=4, OVER=5.
- freeze  out  1  1 = player and bars must hold position.
- rst_player  out  1  one-clk pulse that returns the player to the start position.
- game_over  out  1  high while in OVER.
- win  out  1  high while in OVER, if OVER was reached by clearing MAX_LEVEL.

Behaviour:
- Reset values: state=IDLE, level=1, lives=LIVES_INIT, freeze=1, rst_player=0, game_over=0, win=0, timer=0.
- Edge detect: btn_prev registers reset to 1, so a button held through reset produces no event. rise = btn & ~btn_prev, one clk.
- All outputs are registered. Transitions take effect the clk after the triggering input is sampled.
- freeze=1 in every state except PLAY.
- IDLE:
  - level=1, lives=LIVES_INIT, win=0.
  - start rise -> PLAY with rst_player=1 for one clk.
- PLAY, priority collision > goal > pause rise:
  - collision with lives==1: lives=0, go to OVER, win=0.
  - collision with lives>1: lives-1, timer=DEATH_TICKS, go to DYING.
  - goal with level==MAX_LEVEL: go to OVER, win=1.
  - goal otherwise: timer=LEVELUP_TICKS, go to LEVEL_UP.
  - pause rise: go to PAUSED.
- PAUSED: collision and goal ignored. pause rise -> PLAY. timer frozen.
- DYING and LEVEL_UP:
  - Each tick decrements timer.
  - Tick with timer==1 exits, so the state lasts exactly N ticks.
  - DYING exit: rst_player pulse, go to PLAY.
  - LEVEL_UP exit: level+1, rst_player pulse, go to PLAY.
  - Pause, collision and goal are ignored in both states.
- OVER: start rise -> IDLE, which reinitialises level and lives. The next start rise begins a new game.
- Simultaneous events:
  - collision and goal in the same clk: collision wins.
  - tick coincident with any event: no interaction; tick only matters in DYING/LEVEL_UP.
- Reset mid-operation: in any state, reset forces the reset values on the next edge and aborts any timer. No rst_player pulse is issued.
- level saturates at MAX_LEVEL. lives never underflows below 0.
- Inputs are held stable for at least one clk; no metastability handling inside the block.

Test Plan:
- Reset then start_btn 0->1: rst_player high exactly 1 clk; state=1, level=1, lives=3, freeze=0. Holding start_btn has no further effect.
- In PLAY, pulse goal: state=4, freeze=1. After exactly 60 ticks: level=2, one rst_player pulse, state=1.
- collision in PLAY with lives=3: lives=2, state=3. After 30 ticks: state=1 with rst_player pulse. Third collision: lives=0, state=5, game_over=1, win=0.
- pause rise in PLAY: state=2. collision and goal asserted while paused: no change to lives or level. Second pause rise: state=1.
- collision and goal in the same clk with lives=2: lives=1, state=3, level unchanged. Goal at level=9: state=5, win=1.
- Reset asserted in LEVEL_UP mid-count at level 4: next clk shows state=0, level=1, lives=3, freeze=1, rst_player=0. start_btn held high across reset release: no transition.
